wishbone_manager: RTL and testbench
===================================

# wishbone_manager

Wishbone classic-cycle bus master sitting directly downstream of the memory request handler. It accepts one single-beat read or write request per idle cycle, runs it on the shared Wishbone bus, and holds the handler off with `mem_busy` until the cycle completes. Read data is registered and presented on `data_from_mem` when `mem_busy` falls, so the handler can route it to the VGA, CPU instruction or CPU data client.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: max cycles in BUS state before an abort (timeout build only); range 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on bus error or timeout.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  read request from handler.
- `mem_write`  in  1  write request from handler.
- `adr_to_mem`  in  32  request byte address.
- `data_to_mem`  in  32  write data.
- `sel_to_mem`  in  4  byte-lane select.
- `mem_busy`  out  1  transaction in flight; handler must not issue requests.
- `data_from_mem`  out  32  last completed read data.
- `bus_fault`  out  1  sticky, set by `err_i` or timeout; cleared only by reset.
- `adr_o`  out  32  Wishbone address.
- `dat_o`  out  32  Wishbone write data.
- `sel_o`  out  4  Wishbone select.
- `we_o`  out  1  Wishbone write enable.
- `cyc_o`  out  1  Wishbone cycle.
- `stb_o`  out  1  Wishbone strobe.
- `dat_i`  in  32  Wishbone read data.
- `ack_i`  in  1  Wishbone acknowledge.
- `err_i`  in  1  Wishbone error.

## Operation
- States: IDLE, BUS.
- IDLE: `cyc_o`=`stb_o`=0, `mem_busy`=0. If `mem_read|mem_write` at a rising edge: register `adr_to_mem`, `data_to_mem`, `sel_to_mem` into `adr_o`/`dat_o`/`sel_o`; `we_o` <= `mem_write`; go to BUS.
- `mem_read` and `mem_write` both high: treated as a write; the read is dropped.
- BUS: `cyc_o`=`stb_o`=1, `mem_busy`=1. All bus outputs are held stable.
- `ack_i`=1 in BUS: if `we_o`=0, `data_from_mem` <= `dat_i`; go to IDLE.
- `err_i`=1 in BUS (priority over `ack_i`): if read, `data_from_mem` <= `ERR_DATA`; set `bus_fault`; go to IDLE.
- `ack_i`/`err_i` in IDLE are ignored.
- `data_from_mem` changes only when a read completes. Writes leave it unchanged.
- Request inputs are ignored while in BUS. The handler gates them with `mem_busy` anyway.
- Reset values: `adr_o`, `dat_o`, `data_from_mem` = 0; `sel_o` = 0; `we_o`, `cyc_o`, `stb_o`, `mem_busy`, `bus_fault` = 0; state IDLE; timeout counter 0.
- Reset mid-transaction: everything returns to reset values at that edge. A late `ack_i` after reset is ignored.

## Timing
- Request sampled at edge T (IDLE). `cyc_o`/`stb_o`/`mem_busy` are high from T+1.
- `ack_i` high during cycle T+k (k>=1): completion edge is at the end of cycle T+k.
- From T+k+1: `cyc_o`/`stb_o`/`mem_busy` are low, and `data_from_mem` is valid and stable.
- Zero-wait slave (ack in first BUS cycle): `mem_busy` is high for exactly 1 cycle.
- Back-to-back: a new request can be sampled at the edge ending cycle T+k+1, giving 1 idle bus cycle minimum between transactions.
- All outputs are registered. There is no combinational path from Wishbone inputs to outputs.

## Configuration
- Macro: `WB_MANAGER_TIMEOUT_EN`.
- Defined: an 8-bit counter clears on entry to BUS and increments each BUS cycle without `ack_i`/`err_i`. When the count reaches `TIMEOUT_CYCLES` in BUS with no `ack_i`/`err_i`, the block aborts with the same behaviour as `err_i`: drop `cyc_o`/`stb_o`, set `bus_fault`, and for reads load `ERR_DATA`.
- Undefined: no counter. BUS waits indefinitely for `ack_i`/`err_i`.

## Test plan
- Read, zero-wait: `mem_read`=1, `adr_to_mem`=0x0000_1000; slave acks in first BUS cycle with `dat_i`=0x1234_5678 → `mem_busy` high 1 cycle, `data_from_mem`=0x1234_5678 from the next cycle, `we_o`=0.
- Write, 3 wait states: `mem_write`=1, adr 0x20, data 0xA5A5_0F0F, sel 4'b0011 → bus outputs held 4 cycles, `we_o`=1, `sel_o`=4'b0011, `data_from_mem` unchanged, `mem_busy` falls the cycle after ack.
- Error: read with slave asserting `err_i` → `data_from_mem`=0xDEAD_BEEF, `bus_fault`=1 and sticky across a subsequent good read.
- Reset mid-transaction: `rst` in the 2nd BUS cycle → next cycle `cyc_o`=0, `mem_busy`=0, `data_from_mem`=0; a following `ack_i` pulse changes nothing.
- Read+write together, then back-to-back read: write is performed; the second request is accepted exactly 1 cycle after `mem_busy` falls.
- Timeout (macro defined, `TIMEOUT_CYCLES`=4, slave never acks) → abort after 4 BUS cycles, `bus_fault`=1, `data_from_mem`=`ERR_DATA`. With the macro undefined, `mem_busy` stays high for 100 cycles.

Source files
------------

// File: rtl/wishbone_manager_if.sv
// Wishbone classic-cycle bus signals shared between the manager and a slave.
interface wishbone_manager_if;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [3:0]  sel_o;
   logic        we_o;
   logic        cyc_o;
   logic        stb_o;
   logic [31:0] dat_i;
   logic        ack_i;
   logic        err_i;

   modport master (
      output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
      input  dat_i, ack_i, err_i
   );

   modport slave (
      input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
      output dat_i, ack_i, err_i
   );
endinterface

// File: rtl/wishbone_manager.sv
// Single-beat Wishbone classic master behind the memory request handler.
// Optional bus watchdog enabled by defining WB_MANAGER_TIMEOUT_EN.
module wishbone_manager #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [31:0]         adr_to_mem,
   input  logic [31:0]         data_to_mem,
   input  logic [3:0]          sel_to_mem,
   output logic                mem_busy,
   output logic [31:0]         data_from_mem,
   output logic                bus_fault,
   wishbone_manager_if.master  wb
);

   typedef enum logic {IDLE, BUS} state_t;

   state_t state, state_nxt;
   logic   req_take;
   logic   txn_done;
   logic   txn_fault;
   logic   timeout_hit;

   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic [3:0]  sel_q;
   logic        we_q;

`ifdef WB_MANAGER_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt;

   // Counter idles at zero so it is already clear on the first BUS cycle.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE) begin
         tmo_cnt <= 8'd0;
      end else if (!wb.ack_i && !wb.err_i) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   assign timeout_hit = (state == BUS) && !wb.ack_i && !wb.err_i && (tmo_cnt == TMO_LAST);
`else
   logic unused_tmo;
   assign unused_tmo  = (TIMEOUT_CYCLES == 0);
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_take  = 1'b0;
      txn_fault = 1'b0;
      txn_done  = 1'b0;
      case (state)
         IDLE: begin
            req_take = mem_read | mem_write;
            if (req_take) state_nxt = BUS;
         end
         BUS: begin
            txn_fault = wb.err_i | timeout_hit;
            txn_done  = wb.ack_i | txn_fault;
            if (txn_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture and read-data return; a simultaneous read+write is a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         adr_q         <= 32'd0;
         dat_q         <= 32'd0;
         sel_q         <= 4'd0;
         we_q          <= 1'b0;
         data_from_mem <= 32'd0;
         bus_fault     <= 1'b0;
      end else begin
         if (req_take) begin
            adr_q <= adr_to_mem;
            dat_q <= data_to_mem;
            sel_q <= sel_to_mem;
            we_q  <= mem_write;
         end
         if (txn_done && !we_q) begin
            data_from_mem <= txn_fault ? ERR_DATA : wb.dat_i;
         end
         if (txn_fault) begin
            bus_fault <= 1'b1;
         end
      end
   end

   assign wb.adr_o = adr_q;
   assign wb.dat_o = dat_q;
   assign wb.sel_o = sel_q;
   assign wb.we_o  = we_q;
   assign wb.cyc_o = (state == BUS);
   assign wb.stb_o = (state == BUS);
   assign mem_busy = (state == BUS);

endmodule

// File: tb/tb_wishbone_manager.sv
// Directed self-checking bench for wishbone_manager; bus slave driven by hand.
module tb_wishbone_manager;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] adr_to_mem;
   logic [31:0] data_to_mem;
   logic [3:0]  sel_to_mem;
   logic        mem_busy;
   logic [31:0] data_from_mem;
   logic        bus_fault;

   int n_checks = 0;
   int n_pass   = 0;

   wishbone_manager_if wb_if ();

   wishbone_manager #(
      .TIMEOUT_CYCLES (4),
      .ERR_DATA       (32'hDEAD_BEEF)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .adr_to_mem    (adr_to_mem),
      .data_to_mem   (data_to_mem),
      .sel_to_mem    (sel_to_mem),
      .mem_busy      (mem_busy),
      .data_from_mem (data_from_mem),
      .bus_fault     (bus_fault),
      .wb            (wb_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      adr_to_mem = '0; data_to_mem = '0; sel_to_mem = '0;
      wb_if.dat_i = '0; wb_if.ack_i = 1'b0; wb_if.err_i = 1'b0;
      cyc();
      chk("rst_cyc",   {31'd0, wb_if.cyc_o}, 32'd0);
      chk("rst_stb",   {31'd0, wb_if.stb_o}, 32'd0);
      chk("rst_busy",  {31'd0, mem_busy}, 32'd0);
      chk("rst_data",  data_from_mem, 32'd0);
      chk("rst_fault", {31'd0, bus_fault}, 32'd0);
      chk("rst_adr",   wb_if.adr_o, 32'd0);
      chk("rst_we_sel", {27'd0, wb_if.we_o, wb_if.sel_o}, 32'd0);
      rst = 1'b0;
      cyc();

      // Read, zero-wait slave
      mem_read = 1'b1; adr_to_mem = 32'h0000_1000; sel_to_mem = 4'hF;
      cyc();
      mem_read = 1'b0;
      chk("rd0_busy", {31'd0, mem_busy}, 32'd1);
      chk("rd0_cyc_stb", {30'd0, wb_if.cyc_o, wb_if.stb_o}, 32'd3);
      chk("rd0_adr", wb_if.adr_o, 32'h0000_1000);
      chk("rd0_we", {31'd0, wb_if.we_o}, 32'd0);
      wb_if.ack_i = 1'b1; wb_if.dat_i = 32'h1234_5678;
      cyc();
      wb_if.ack_i = 1'b0; wb_if.dat_i = 32'h0;
      chk("rd0_busy_fall", {31'd0, mem_busy}, 32'd0);
      chk("rd0_cyc_fall", {31'd0, wb_if.cyc_o}, 32'd0);
      chk("rd0_data", data_from_mem, 32'h1234_5678);
      cyc();
      chk("rd0_data_hold", data_from_mem, 32'h1234_5678);

      // Write with 3 wait states
      mem_write = 1'b1; adr_to_mem = 32'h20; data_to_mem = 32'hA5A5_0F0F; sel_to_mem = 4'b0011;
      cyc();
      mem_write = 1'b0; adr_to_mem = 32'hFFFF_FFFF; data_to_mem = 32'h0; sel_to_mem = 4'hF;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wr_busy%0d", i), {31'd0, mem_busy}, 32'd1);
         chk($sformatf("wr_we_sel%0d", i), {27'd0, wb_if.we_o, wb_if.sel_o}, 32'h13);
         chk($sformatf("wr_adr%0d", i), wb_if.adr_o, 32'h20);
         chk($sformatf("wr_dat%0d", i), wb_if.dat_o, 32'hA5A5_0F0F);
         if (i == 3) wb_if.ack_i = 1'b1;
         cyc();
      end
      wb_if.ack_i = 1'b0;
      chk("wr_busy_fall", {31'd0, mem_busy}, 32'd0);
      chk("wr_data_keep", data_from_mem, 32'h1234_5678);

      // Bus error on read, ack asserted too (error wins)
      mem_read = 1'b1; adr_to_mem = 32'h40;
      cyc();
      mem_read = 1'b0;
      chk("err_busy", {31'd0, mem_busy}, 32'd1);
      wb_if.err_i = 1'b1; wb_if.ack_i = 1'b1; wb_if.dat_i = 32'h1111_1111;
      cyc();
      wb_if.err_i = 1'b0; wb_if.ack_i = 1'b0;
      chk("err_data", data_from_mem, 32'hDEAD_BEEF);
      chk("err_fault", {31'd0, bus_fault}, 32'd1);
      chk("err_busy_fall", {31'd0, mem_busy}, 32'd0);
      mem_read = 1'b1; adr_to_mem = 32'h44;
      cyc();
      mem_read = 1'b0;
      wb_if.ack_i = 1'b1; wb_if.dat_i = 32'hCAFE_F00D;
      cyc();
      wb_if.ack_i = 1'b0;
      chk("err_good_data", data_from_mem, 32'hCAFE_F00D);
      chk("err_sticky", {31'd0, bus_fault}, 32'd1);

      // Reset in the second BUS cycle, then a stray ack
      mem_read = 1'b1; adr_to_mem = 32'h80;
      cyc();
      mem_read = 1'b0;
      chk("mrst_busy", {31'd0, mem_busy}, 32'd1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mrst_cyc", {31'd0, wb_if.cyc_o}, 32'd0);
      chk("mrst_busy0", {31'd0, mem_busy}, 32'd0);
      chk("mrst_data", data_from_mem, 32'd0);
      chk("mrst_fault", {31'd0, bus_fault}, 32'd0);
      wb_if.ack_i = 1'b1; wb_if.dat_i = 32'h5555_5555;
      cyc();
      wb_if.ack_i = 1'b0;
      chk("late_ack_data", data_from_mem, 32'd0);
      chk("late_ack_busy", {31'd0, mem_busy}, 32'd0);
      chk("late_ack_cyc", {31'd0, wb_if.cyc_o}, 32'd0);

      // Read+write together, then back-to-back read
      mem_read = 1'b1; mem_write = 1'b1; adr_to_mem = 32'h100; data_to_mem = 32'h0BAD_F00D;
      cyc();
      mem_write = 1'b0;
      chk("rw_we", {31'd0, wb_if.we_o}, 32'd1);
      chk("rw_busy", {31'd0, mem_busy}, 32'd1);
      mem_read = 1'b1; adr_to_mem = 32'h104;
      wb_if.ack_i = 1'b1; wb_if.dat_i = 32'h7777_7777;
      cyc();
      wb_if.ack_i = 1'b0;
      chk("rw_busy_fall", {31'd0, mem_busy}, 32'd0);
      chk("rw_data_keep", data_from_mem, 32'd0);
      chk("rw_adr_hold", wb_if.adr_o, 32'h100);
      cyc();
      mem_read = 1'b0;
      chk("b2b_busy", {31'd0, mem_busy}, 32'd1);
      chk("b2b_adr", wb_if.adr_o, 32'h104);
      chk("b2b_we", {31'd0, wb_if.we_o}, 32'd0);
      wb_if.ack_i = 1'b1; wb_if.dat_i = 32'h600D_DA7A;
      cyc();
      wb_if.ack_i = 1'b0;
      chk("b2b_data", data_from_mem, 32'h600D_DA7A);

      // Silent slave
      mem_read = 1'b1; adr_to_mem = 32'h200;
      cyc();
      mem_read = 1'b0;
      n = 0;
`ifdef WB_MANAGER_TIMEOUT_EN
      while (mem_busy && n < 110) begin
         n++;
         cyc();
      end
      chk("tmo_cycles", n, 32'd4);
      chk("tmo_fault", {31'd0, bus_fault}, 32'd1);
      chk("tmo_data", data_from_mem, 32'hDEAD_BEEF);
      chk("tmo_cyc", {31'd0, wb_if.cyc_o}, 32'd0);
`else
      while (mem_busy && n < 100) begin
         n++;
         cyc();
      end
      chk("notmo_cycles", n, 32'd100);
      chk("notmo_busy", {31'd0, mem_busy}, 32'd1);
      wb_if.ack_i = 1'b1; wb_if.dat_i = 32'h0F0F_0F0F;
      cyc();
      wb_if.ack_i = 1'b0;
      chk("notmo_end_busy", {31'd0, mem_busy}, 32'd0);
      chk("notmo_data", data_from_mem, 32'h0F0F_0F0F);
      chk("notmo_fault", {31'd0, bus_fault}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
